// File: rtl/ccu_pkg.sv
// Shared types and round-count constants for the parametrised AES control unit.
package ccu_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_KEY_WAIT,
        ST_KEY_EXP,
        ST_DEC_KEY,
        ST_IRQ,
        ST_SERVICED,
        ST_RCU_WAIT,
        ST_ROUND,
        ST_HOLD,
        ST_FINISHED
    } ccu_state_t;

    localparam int AES128_ROUNDS = 10;
    localparam int AES192_ROUNDS = 12;
    localparam int AES256_ROUNDS = 14;

    function automatic bit rounds_legal(input int n);
        return (n == AES128_ROUNDS) || (n == AES192_ROUNDS) || (n == AES256_ROUNDS);
    endfunction

endpackage

// File: rtl/ccu_round_ctr.sv
// Round counter: load to 1, count up, terminal-count flag at NUM_ROUNDS; clear wins.
module ccu_round_ctr
    import ccu_pkg::*;
#(
    parameter int RCNT_W     = 4,
    parameter int NUM_ROUNDS = AES128_ROUNDS
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clr,
    input  logic              load,
    input  logic              inc,
    output logic [RCNT_W-1:0] count,
    output logic              tc
);

    localparam logic [RCNT_W-1:0] LAST = RCNT_W'(NUM_ROUNDS);

    always_ff @(posedge clk) begin
        if (!n_rst || clr) begin
            count <= '0;
        end else if (load) begin
            count <= RCNT_W'(1);
        end else if (inc && !tc) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/ccu_param.sv
// Sequencer for key expansion, data-load IRQ handshake and NUM_ROUNDS round cycles,
// with multi-block bursts that reuse the expanded key and a synchronous abort.
//
// state       | meaning
// IDLE        | unit free, waiting for enable
// KEY_WAIT    | waiting for key load (read)
// KEY_EXP     | forward key expansion running
// DEC_KEY     | inverse expansion pass (decrypt only)
// IRQ         | requesting next data block
// SERVICED    | host acknowledged, waiting for data_done
// RCU_WAIT    | one-cycle setup before rounds
// ROUND       | NUM_ROUNDS round cycles
// HOLD        | waiting for datapath aes_done
// FINISHED    | burst complete, waiting for enable release
module ccu_param
    import ccu_pkg::*;
#(
    parameter int NUM_ROUNDS = AES128_ROUNDS,
    parameter int RCNT_W     = 4,
    parameter int BCNT_W     = 5
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              enable,
    input  logic              e_or_d,
    input  logic [BCNT_W-1:0] num_blocks,
    input  logic              read,
    input  logic              key_expanded,
    input  logic              irq_resp,
    input  logic              data_done,
    input  logic              aes_done,
    input  logic              abort,
    output logic              ed_sel,
    output logic              start_op,
    output logic              irq,
    output logic              key_op,
    output logic              ready,
    output logic [RCNT_W-1:0] round_num,
    output logic              round_active,
    output logic [BCNT_W-1:0] blocks_done
);

    ccu_state_t        state;
    logic              mode;
    logic [BCNT_W-1:0] nblk;
    logic [BCNT_W-1:0] bcnt;
    logic [BCNT_W-1:0] bcnt_nxt;
    logic              rc_clr;
    logic              rc_load;
    logic              rc_inc;
    logic              rc_tc;
    logic [RCNT_W-1:0] rc_count;
    logic              do_abort;

    assign do_abort = abort && (state != ST_IDLE);
    assign bcnt_nxt = bcnt + 1'b1;

    always_comb begin
        rc_clr  = do_abort || ((state == ST_ROUND) && rc_tc);
        rc_load = (state == ST_RCU_WAIT);
        rc_inc  = (state == ST_ROUND);
    end

    ccu_round_ctr #(
        .RCNT_W     (RCNT_W),
        .NUM_ROUNDS (NUM_ROUNDS)
    ) u_round_ctr (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (rc_clr),
        .load  (rc_load),
        .inc   (rc_inc),
        .count (rc_count),
        .tc    (rc_tc)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= ST_IDLE;
            irq   <= 1'b0;
            bcnt  <= '0;
            mode  <= 1'b0;
            nblk  <= BCNT_W'(1);
        end else if (do_abort) begin
            state <= ST_IDLE;
            irq   <= 1'b0;
            bcnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        mode  <= e_or_d;
                        nblk  <= (num_blocks == '0) ? BCNT_W'(1) : num_blocks;
                        bcnt  <= '0;
                        state <= ST_KEY_WAIT;
                    end
                end
                ST_KEY_WAIT: begin
                    if (read) state <= ST_KEY_EXP;
                end
                ST_KEY_EXP: begin
                    if (key_expanded) begin
                        if (mode) begin
                            state <= ST_IRQ;
                            irq   <= 1'b1;
                        end else begin
                            state <= ST_DEC_KEY;
                        end
                    end
                end
                ST_DEC_KEY: begin
                    if (key_expanded) begin
                        state <= ST_IRQ;
                        irq   <= 1'b1;
                    end
                end
                ST_IRQ: begin
                    if (irq_resp) begin
                        state <= ST_SERVICED;
                        irq   <= 1'b0;
                    end
                end
                ST_SERVICED: begin
                    if (data_done) state <= ST_RCU_WAIT;
                end
                ST_RCU_WAIT: begin
                    state <= ST_ROUND;
                end
                ST_ROUND: begin
                    if (rc_tc) state <= ST_HOLD;
                end
                ST_HOLD: begin
                    // Later blocks go straight back to IRQ: the expanded key is reused.
                    if (aes_done) begin
                        bcnt <= bcnt_nxt;
                        if (bcnt_nxt == nblk) begin
                            state <= ST_FINISHED;
                        end else begin
                            state <= ST_IRQ;
                            irq   <= 1'b1;
                        end
                    end
                end
                ST_FINISHED: begin
                    if (!enable) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ed_sel       = (state != ST_IDLE) && mode;
        start_op     = (state == ST_KEY_EXP);
        ready        = (state == ST_IDLE) || (state == ST_FINISHED);
        round_active = (state == ST_ROUND);
        key_op       = (state == ST_ROUND) && rc_tc;
        round_num    = rc_count;
        blocks_done  = bcnt;
    end

endmodule

// File: tb/tb_ccu_param.sv
// Bench for ccu_param: vector table, hand-written corner sequences and randomized bursts
// checked against transaction-level expectations, on a 10-round and a 14-round instance.
module tb_ccu_param;

    localparam int RW = 4;
    localparam int BW = 5;

    typedef struct packed {
        logic          enable;
        logic          e_or_d;
        logic [BW-1:0] num_blocks;
        logic          read;
        logic          key_expanded;
        logic          irq_resp;
        logic          data_done;
        logic          aes_done;
        logic          abort;
    } in_t;

    typedef struct packed {
        logic          ed_sel;
        logic          start_op;
        logic          irq;
        logic          key_op;
        logic          ready;
        logic          round_active;
        logic [RW-1:0] round_num;
        logic [BW-1:0] blocks_done;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    logic          clk = 1'b0;
    logic          n_rst [2];
    in_t           din [2];
    logic          ed_sel [2];
    logic          start_op [2];
    logic          irq [2];
    logic          key_op [2];
    logic          ready [2];
    logic          round_active [2];
    logic [RW-1:0] round_num [2];
    logic [BW-1:0] blocks_done [2];

    int nr_of [2] = '{10, 14};
    int n_cmp = 0;
    int n_err = 0;

    bit            mon_on = 0;
    bit            exp_mode [2];
    int            irq_rises [2];
    int            st_cycles [2];
    int            ra_cycles [2];
    logic          prev_irq [2];
    logic          prev_ra [2];
    logic [RW-1:0] prev_rn [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ccu_param #(
            .NUM_ROUNDS (g == 0 ? 10 : 14),
            .RCNT_W     (RW),
            .BCNT_W     (BW)
        ) dut (
            .clk          (clk),
            .n_rst        (n_rst[g]),
            .enable       (din[g].enable),
            .e_or_d       (din[g].e_or_d),
            .num_blocks   (din[g].num_blocks),
            .read         (din[g].read),
            .key_expanded (din[g].key_expanded),
            .irq_resp     (din[g].irq_resp),
            .data_done    (din[g].data_done),
            .aes_done     (din[g].aes_done),
            .abort        (din[g].abort),
            .ed_sel       (ed_sel[g]),
            .start_op     (start_op[g]),
            .irq          (irq[g]),
            .key_op       (key_op[g]),
            .ready        (ready[g]),
            .round_num    (round_num[g]),
            .round_active (round_active[g]),
            .blocks_done  (blocks_done[g])
        );
    end

    function automatic out_t get_out(input int g);
        out_t o;
        o.ed_sel       = ed_sel[g];
        o.start_op     = start_op[g];
        o.irq          = irq[g];
        o.key_op       = key_op[g];
        o.ready        = ready[g];
        o.round_active = round_active[g];
        o.round_num    = round_num[g];
        o.blocks_done  = blocks_done[g];
        return o;
    endfunction

    function automatic in_t fi(input logic en, ed, rd, kx, ir, dd, ad, input logic [BW-1:0] nb);
        in_t i;
        i = '0;
        i.enable = en; i.e_or_d = ed; i.read = rd; i.key_expanded = kx;
        i.irq_resp = ir; i.data_done = dd; i.aes_done = ad; i.num_blocks = nb;
        return i;
    endfunction

    function automatic out_t fo(input logic ed, so, iq, ko, rdy, ra, input logic [RW-1:0] rn,
                                input logic [BW-1:0] bd);
        out_t o;
        o.ed_sel = ed; o.start_op = so; o.irq = iq; o.key_op = ko; o.ready = rdy;
        o.round_active = ra; o.round_num = rn; o.blocks_done = bd;
        return o;
    endfunction

    function automatic vec_t mk(input in_t i, input out_t o);
        vec_t v;
        v.i = i;
        v.o = o;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    // Round numbering is predicted from "1 on entry, +1 per cycle", never from DUT state.
    task automatic mon(input int g);
        out_t          o;
        logic [RW-1:0] ern;
        o = get_out(g);
        if (!mon_on) return;
        if (o.irq && !prev_irq[g]) irq_rises[g]++;
        prev_irq[g] = o.irq;
        if (o.start_op) st_cycles[g]++;
        if (o.round_active) begin
            ern = prev_ra[g] ? prev_rn[g] + 1'b1 : RW'(1);
            ra_cycles[g]++;
            chk("round_num_seq", 32'(o.round_num), 32'(ern));
            chk("key_op_round", 32'(o.key_op), 32'(ern == RW'(nr_of[g])));
            chk("ed_sel_round", 32'(o.ed_sel), 32'(exp_mode[g]));
            prev_rn[g] = ern;
        end else begin
            chk("rn_outside_round", {o.round_num, o.key_op}, 32'd0);
        end
        prev_ra[g] = o.round_active;
    endtask

    task automatic step(input int g);
        @(posedge clk);
        #1;
        mon(g);
    endtask

    task automatic go_to_irq(input int g, input bit mode);
        int k;
        din[g] = '0;
        din[g].enable = 1'b1;
        din[g].e_or_d = mode;
        din[g].num_blocks = BW'(1);
        step(g);
        din[g] = '0;
        din[g].read = 1'b1;
        din[g].key_expanded = 1'b1;
        k = 0;
        do begin
            step(g);
            k++;
        end while (!irq[g] && k < 10);
        chk("go_to_irq", 32'(irq[g]), 32'd1);
        din[g] = '0;
    endtask

    task automatic to_rounds(input int g);
        din[g].irq_resp = 1'b1;
        step(g);
        din[g].irq_resp = 1'b0;
        din[g].data_done = 1'b1;
        step(g);
        din[g].data_done = 1'b0;
        step(g);
    endtask

    task automatic run_op(input int g, input bit mode, input int nb_raw);
        int  nb;
        int  nr;
        int  k;
        bit  seen;
        nb = (nb_raw == 0) ? 1 : nb_raw;
        nr = nr_of[g];
        exp_mode[g] = mode;
        irq_rises[g] = 0; st_cycles[g] = 0; ra_cycles[g] = 0;
        prev_irq[g] = irq[g]; prev_ra[g] = 1'b0; prev_rn[g] = '0;
        mon_on = 1;
        din[g] = '0;
        din[g].enable = 1'b1;
        din[g].e_or_d = mode;
        din[g].num_blocks = BW'(nb_raw);
        step(g);
        din[g].enable = 1'b0;
        din[g].e_or_d = ~mode;
        din[g].num_blocks = BW'($urandom_range(0, 31));
        chk("ed_latch", 32'(ed_sel[g]), 32'(mode));
        chk("busy_ready", 32'(ready[g]), 32'd0);
        repeat ($urandom_range(0, 3)) step(g);
        din[g].read = 1'b1;
        din[g].key_expanded = 1'b1;
        k = 0;
        do begin
            step(g);
            k++;
        end while (!irq[g] && k < 20);
        chk("read_to_irq", 32'(k), mode ? 32'd2 : 32'd3);
        din[g].read = 1'b0;
        din[g].key_expanded = 1'b0;
        for (int b = 0; b < nb; b++) begin
            repeat ($urandom_range(0, 2)) step(g);
            chk("irq_hold", 32'(irq[g]), 32'd1);
            din[g].irq_resp = 1'b1;
            step(g);
            din[g].irq_resp = 1'b0;
            chk("irq_clear", 32'(irq[g]), 32'd0);
            repeat ($urandom_range(0, 3)) step(g);
            din[g].data_done = 1'b1;
            step(g);
            din[g].data_done = 1'b0;
            k = 1;
            seen = 0;
            while (k < 60) begin
                if (round_active[g]) seen = 1;
                else if (seen) break;
                step(g);
                k++;
            end
            chk("dd_to_hold", 32'(k), 32'(nr + 2));
            repeat ($urandom_range(0, 3)) step(g);
            chk("bd_before", 32'(blocks_done[g]), 32'(b));
            din[g].aes_done = 1'b1;
            step(g);
            din[g].aes_done = 1'b0;
            chk("bd_after", 32'(blocks_done[g]), 32'(b + 1));
            chk("ready_after", 32'(ready[g]), 32'(b == nb - 1));
            chk("irq_next", 32'(irq[g]), 32'(b != nb - 1));
        end
        chk("irq_count", 32'(irq_rises[g]), 32'(nb));
        chk("start_op_cycles", 32'(st_cycles[g]), 32'd1);
        chk("round_cycles", 32'(ra_cycles[g]), 32'(nb * nr));
        din[g].enable = 1'b1;
        repeat ($urandom_range(1, 3)) step(g);
        chk("fin_hold", {ready[g], 3'b0, blocks_done[g]}, {1'b1, 3'b0, BW'(nb)});
        din[g].enable = 1'b0;
        step(g);
        chk("back_idle", {ready[g], ed_sel[g]}, 32'b10);
        mon_on = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        out_t idle_o;
        int   rc;
        int   kc;

        idle_o = '0;
        idle_o.ready = 1'b1;

        tbl.push_back(mk(fi(1, 1, 0, 0, 0, 0, 0, 1), fo(1, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(fi(0, 0, 1, 0, 0, 0, 0, 7), fo(1, 1, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(fi(0, 0, 0, 1, 0, 0, 0, 0), fo(1, 0, 1, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(fi(0, 1, 0, 0, 0, 0, 0, 0), fo(1, 0, 1, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(fi(0, 0, 0, 0, 1, 0, 0, 0), fo(1, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(fi(0, 0, 0, 0, 0, 1, 0, 0), fo(1, 0, 0, 0, 0, 0, 0, 0)));
        for (int r = 1; r <= 10; r++)
            tbl.push_back(mk(fi(0, 0, 0, 0, 0, 0, 0, 0),
                             fo(1, 0, 0, r == 10, 0, 1, RW'(r), 0)));
        tbl.push_back(mk(fi(0, 0, 0, 0, 0, 0, 0, 0), fo(1, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(fi(0, 0, 0, 0, 0, 0, 0, 0), fo(1, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(fi(0, 0, 0, 0, 0, 0, 1, 0), fo(1, 0, 0, 0, 1, 0, 0, 1)));
        tbl.push_back(mk(fi(1, 0, 0, 0, 0, 0, 0, 0), fo(1, 0, 0, 0, 1, 0, 0, 1)));
        tbl.push_back(mk(fi(0, 0, 0, 0, 0, 0, 0, 0), fo(0, 0, 0, 0, 1, 0, 0, 1)));

        din[0] = '0;
        din[1] = '0;
        n_rst[0] = 1'b0;
        n_rst[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_rst[0] = 1'b1;
        n_rst[1] = 1'b1;
        chk("reset_out_r10", get_out(0), idle_o);
        chk("reset_out_r14", get_out(1), idle_o);

        // Single-block encrypt, 10 rounds, one row per clock edge.
        foreach (tbl[k]) begin
            din[0] = tbl[k].i;
            step(0);
            chk($sformatf("vec%0d", k), get_out(0), tbl[k].o);
        end
        din[0] = '0;

        // Decrypt, 14 rounds, two separate expansion passes.
        din[1].enable = 1'b1;
        step(1);
        din[1] = '0;
        din[1].read = 1'b1;
        step(1);
        din[1] = '0;
        chk("dec_key_exp", {start_op[1], ed_sel[1]}, 32'b10);
        din[1].key_expanded = 1'b1;
        step(1);
        din[1].key_expanded = 1'b0;
        chk("dec_pass2_start_op", 32'(start_op[1]), 32'd0);
        step(1);
        step(1);
        chk("dec_no_early_irq", 32'(irq[1]), 32'd0);
        din[1].key_expanded = 1'b1;
        step(1);
        din[1].key_expanded = 1'b0;
        chk("dec_irq", {irq[1], ed_sel[1]}, 32'b10);
        to_rounds(1);
        rc = 0;
        kc = 0;
        while (round_active[1] && rc < 40) begin
            rc++;
            chk("dec_ed_sel", 32'(ed_sel[1]), 32'd0);
            if (key_op[1]) begin
                kc++;
                chk("dec_key_op_at", 32'(round_num[1]), 32'd14);
            end
            step(1);
        end
        chk("dec_round_cycles", 32'(rc), 32'd14);
        chk("dec_key_op_count", 32'(kc), 32'd1);
        din[1].aes_done = 1'b1;
        step(1);
        din[1].aes_done = 1'b0;
        chk("dec_finished", {ready[1], 3'b0, blocks_done[1]}, {1'b1, 3'b0, BW'(1)});
        step(1);

        // Abort at round 5 (irq low), then abort in IRQ (irq high).
        go_to_irq(0, 1'b1);
        to_rounds(0);
        repeat (4) step(0);
        chk("abort_at_rn5", {irq[0], 3'b0, round_num[0]}, 32'd5);
        din[0].abort = 1'b1;
        step(0);
        din[0].abort = 1'b0;
        chk("abort_round", get_out(0), idle_o);
        go_to_irq(0, 1'b0);
        din[0].abort = 1'b1;
        step(0);
        din[0].abort = 1'b0;
        chk("abort_irq", get_out(0), idle_o);
        run_op(0, 1'b1, 2);

        // Reset mid-round with e_or_d toggling.
        go_to_irq(1, 1'b1);
        to_rounds(1);
        for (int t = 0; t < 4; t++) begin
            din[1].e_or_d = t[0];
            step(1);
            chk("ed_ignore_toggle", 32'(ed_sel[1]), 32'd1);
        end
        n_rst[1] = 1'b0;
        step(1);
        chk("mid_reset", get_out(1), idle_o);
        n_rst[1] = 1'b1;
        din[1] = '0;
        run_op(1, 1'b1, 1);

        run_op(0, 1'b1, 3);
        run_op(0, 1'b1, 0);
        run_op(1, 1'b0, 2);

        for (int n = 0; n < 8; n++)
            run_op(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 4)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ccu_param.md
Name: ccu_param

Overview:
Parametrised cryptographic control unit that sequences key expansion, the data-load interrupt handshake, and N round cycles for one AES engine.
Generalises the fixed 10-round CCU in three ways:
- round count is a parameter (10/12/14 for AES-128/192/256), driven by a counter rather than one state per round;
- multi-block burst mode reuses the expanded key, so keys are not re-expanded per block;
- synchronous abort.
Sits between the bus-side register/IRQ logic and the key-expansion/round datapath.

Parameters:
NUM_ROUNDS, 10, number of round cycles per block; legal values 10, 12, 14.
RCNT_W, 4, round counter width; must satisfy 2^RCNT_W > NUM_ROUNDS.
BCNT_W, 5, block counter width; maximum burst is 2^BCNT_W - 1 blocks.

Ports:
clk  in  1  system clock; one clock, all logic on its rising edge
n_rst  in  1  reset; synchronous, active-low
enable  in  1  start request (IDLE); release request (FINISHED)
e_or_d  in  1  1 = encrypt, 0 = decrypt; sampled in IDLE only
num_blocks  in  BCNT_W  burst length; sampled in IDLE; 0 is treated as 1
read  in  1  key loaded
key_expanded  in  1  key expansion pass complete
irq_resp  in  1  host acknowledge of irq
data_done  in  1  data block loaded
aes_done  in  1  datapath finished current block
abort  in  1  cancel operation
ed_sel  out  1  latched mode (1 = encrypt); 0 in IDLE
start_op  out  1  kick key expansion
irq  out  1  registered interrupt, requests next data block
key_op  out  1  final-round key select
ready  out  1  unit idle or finished
round_num  out  RCNT_W  current round, 1..NUM_ROUNDS; 0 outside ROUND
round_active  out  1  high in ROUND state
blocks_done  out  BCNT_W  blocks completed in current burst

Behaviour:
- Reset (n_rst=0 at a clk edge):
  - state=IDLE; irq=0, round counter=0, block counter=0, mode=0, nblk=1.
  - Combinational outputs settle to IDLE values: ready=1, all other outputs 0.
- States: IDLE, KEY_WAIT, KEY_EXP, DEC_KEY, IRQ, SERVICED, RCU_WAIT, ROUND, HOLD, FINISHED.
- IDLE: ready=1. When enable=1: latch mode<=e_or_d, nblk<=(num_blocks==0 ? 1 : num_blocks), blocks_done<=0; go to KEY_WAIT.
- KEY_WAIT: read=1 -> KEY_EXP.
- KEY_EXP: start_op=1. On key_expanded=1:
  - encrypt -> IRQ, with irq set on the same edge;
  - decrypt -> DEC_KEY.
- DEC_KEY: second (inverse) expansion pass. start_op=0. key_expanded=1 -> IRQ, irq set on the same edge.
- IRQ: irq held at 1. irq_resp=1 -> SERVICED, irq cleared on the same edge. irq_resp in the first IRQ cycle is legal.
- SERVICED: data_done=1 -> RCU_WAIT.
- RCU_WAIT: one cycle, then ROUND with round counter<=1.
- ROUND: round_active=1, round_num=counter.
  - key_op=1 only when counter==NUM_ROUNDS.
  - Counter increments each cycle; after the NUM_ROUNDS cycle -> HOLD, counter<=0.
  - Exactly NUM_ROUNDS cycles in ROUND.
- HOLD: both modes wait here. On aes_done=1, blocks_done increments and:
  - if the new count == nblk -> FINISHED;
  - else -> IRQ with irq set. No new key expansion; start_op stays 0.
- FINISHED: ready=1. enable=0 -> IDLE. enable held high keeps the unit in FINISHED; blocks_done holds its value.
- ed_sel = latched mode in every state except IDLE. e_or_d and num_blocks changes after leaving IDLE are ignored.
- abort=1 in any non-IDLE state -> IDLE next edge; irq<=0, counters<=0. Abort has priority over every other transition. abort in IDLE has no effect.
- enable dropping in any state other than FINISHED is ignored; only abort cancels.
- Reset mid-operation behaves identically to a power-on reset.
- Latency:
  - encrypt, read to irq rising: 2 edges when key_expanded is already high on KEY_EXP entry;
  - data_done to first ROUND cycle: 2 edges;
  - data_done to HOLD entry: NUM_ROUNDS+2 edges.
- round_num and block counters are unsigned and never wrap: bounded by NUM_ROUNDS and nblk.

Decomposition:
- Package ccu_pkg holds:
  - ccu_state_t enum (4-bit);
  - localparams AES128_ROUNDS=10, AES192_ROUNDS=12, AES256_ROUNDS=14.
- Sub-module ccu_round_ctr: loadable up-counter with terminal-count flag, parametrised by RCNT_W and NUM_ROUNDS. Drives round_num, key_op and the ROUND exit.
- The FSM and block counter stay in ccu_param.

Test Plan:
1. Encrypt, NUM_ROUNDS=10, num_blocks=1: enable, read, key_expanded, irq_resp, data_done, then aes_done 3 cycles after HOLD entry -> irq high exactly while in IRQ; round_num steps 1..10 over 10 cycles; key_op high only at round 10; ready=1 in FINISHED; IDLE the cycle after enable=0.
2. Decrypt, NUM_ROUNDS=14: key_expanded asserted twice (KEY_EXP, then DEC_KEY) -> ed_sel=0 throughout; irq rises only after the second pass; 14 ROUND cycles; key_op at round 14.
3. Burst num_blocks=3, encrypt -> start_op pulses only in KEY_EXP; irq asserted 3 times; blocks_done goes 1, 2, 3; FINISHED after the third aes_done.
4. num_blocks=0 -> behaves as 1 block; blocks_done=1 at FINISHED.
5. abort at round 5 with irq low, and separately abort in IRQ with irq=1 -> IDLE next edge; irq=0, round_num=0, ready=1. A following enable starts cleanly.
6. n_rst=0 for one edge during ROUND; e_or_d toggled mid-operation -> all outputs return to reset values after that edge; ed_sel never follows the mid-operation e_or_d toggle.
